// File: rtl/moving_avg_ctrl.sv
// Sequencer in front of one moving-average engine: paces samples, owns engine reset.
// Define MAVG_CTRL_WARMUP_PASS_EN to also forward partial-window results in FILL.
module moving_avg_ctrl #(
  parameter int FIFO_ADDR_WIDTH = 10,
  parameter int DIN_WIDTH       = 16,
  parameter int MIN_GAP         = 2,
  parameter int RST_CYCLES      = 4,
  parameter int RESP_TIMEOUT    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [DIN_WIDTH-1:0]   s_data,
  input  logic                   s_valid,
  output logic                   s_ready,
  output logic                   eng_rstn,
  output logic [DIN_WIDTH-1:0]   eng_din,
  output logic                   eng_din_valid,
  input  logic [DIN_WIDTH-1:0]   eng_avg,
  input  logic                   eng_avg_valid,
  input  logic [DIN_WIDTH-1:0]   eng_ac,
  output logic [DIN_WIDTH-1:0]   m_avg,
  output logic [DIN_WIDTH-1:0]   m_ac,
  output logic                   m_valid,
  output logic                   win_full,
  output logic [FIFO_ADDR_WIDTH:0] fill_cnt,
  output logic                   err_timeout
);

  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int GW = $clog2(MIN_GAP + 1);
  localparam int TW = $clog2(RESP_TIMEOUT + 1);

  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(RESP_TIMEOUT - 1);
  localparam logic [FIFO_ADDR_WIDTH:0] FULL =
    {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [FIFO_ADDR_WIDTH:0] LAST =
    {1'b0, {FIFO_ADDR_WIDTH{1'b1}}};

  typedef enum logic [1:0] {
    ENG_RST,
    FILL,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [RW-1:0] rst_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] to_cnt;
  logic          outstanding;
  logic          accept;
  logic          resp;
  logic          timeout;
  logic          fill_last;
  logic          fwd;
  logic          restart;

  assign fill_last = fill_cnt == LAST;
  assign s_ready   = (state_q == FILL || state_q == RUN)
                  && !outstanding && gap_cnt == '0 && !flush;
  assign accept    = s_valid && s_ready;
  assign resp      = eng_avg_valid && outstanding && !flush;
  assign timeout   = outstanding && !eng_avg_valid && !flush
                  && to_cnt == TO_LAST;
  assign eng_rstn  = state_q != ENG_RST;
  assign win_full  = state_q == RUN;
  assign restart   = state_q == ENG_RST || state_d == ENG_RST;

`ifdef MAVG_CTRL_WARMUP_PASS_EN
  assign fwd = resp;
`else
  assign fwd = resp && (state_q == RUN || fill_last);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ENG_RST: if (rst_cnt == RST_LAST) state_d = FILL;
      FILL:    if (resp && fill_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = ENG_RST;
    endcase
    if (flush || timeout) state_d = ENG_RST;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ENG_RST;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_cnt       <= '0;
      gap_cnt       <= '0;
      to_cnt        <= '0;
      outstanding   <= 1'b0;
      fill_cnt      <= '0;
      err_timeout   <= 1'b0;
      eng_din       <= '0;
      eng_din_valid <= 1'b0;
      m_avg         <= '0;
      m_ac          <= '0;
      m_valid       <= 1'b0;
    end else begin
      eng_din_valid <= accept;
      m_valid       <= fwd;
      if (accept) eng_din <= s_data;
      if (fwd) begin
        m_avg <= eng_avg;
        m_ac  <= eng_ac;
      end
      if (timeout) err_timeout <= 1'b1;
      if (restart) begin
        // stay in ENG_RST counts up; any fresh entry restarts the count
        rst_cnt     <= (state_q == ENG_RST && state_d == ENG_RST && !flush)
                     ? rst_cnt + 1'b1 : '0;
        gap_cnt     <= '0;
        to_cnt      <= '0;
        outstanding <= 1'b0;
        fill_cnt    <= '0;
      end else begin
        if (accept) begin
          outstanding <= 1'b1;
          gap_cnt     <= GAP_LOAD;
          to_cnt      <= '0;
        end else begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
          if (resp)             outstanding <= 1'b0;
          else if (outstanding) to_cnt <= to_cnt + 1'b1;
        end
        if (resp && fill_cnt != FULL) fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_moving_avg_ctrl.sv
// Bench for moving_avg_ctrl: behavioural engine, scoreboard and vector table.
// Build with MAVG_CTRL_WARMUP_PASS_EN to check the warm-up forwarding variant.
module tb_moving_avg_ctrl;

  localparam int AW  = 2;
  localparam int DW  = 16;
  localparam int GAP = 3;
  localparam int RC  = 4;
  localparam int TO  = 8;

`ifdef MAVG_CTRL_WARMUP_PASS_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, flush, s_valid, s_ready;
  logic          eng_rstn, eng_din_valid, eng_avg_valid;
  logic          m_valid, win_full, err_timeout;
  logic [DW-1:0] s_data, eng_din, eng_avg, eng_ac, m_avg, m_ac;
  logic [AW:0]   fill_cnt;

  always #5 clk = ~clk;

  moving_avg_ctrl #(
    .FIFO_ADDR_WIDTH(AW), .DIN_WIDTH(DW), .MIN_GAP(GAP),
    .RST_CYCLES(RC), .RESP_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .eng_rstn(eng_rstn), .eng_din(eng_din),
    .eng_din_valid(eng_din_valid),
    .eng_avg(eng_avg), .eng_avg_valid(eng_avg_valid),
    .eng_ac(eng_ac),
    .m_avg(m_avg), .m_ac(m_ac), .m_valid(m_valid),
    .win_full(win_full), .fill_cnt(fill_cnt),
    .err_timeout(err_timeout)
  );

  typedef struct {
    logic [DW-1:0] avg;
    logic [DW-1:0] ac;
    logic          wf;
  } exp_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] avg;
    logic [DW-1:0] ac;
    logic          fwd;
    logic          wf;
    logic [AW:0]   fill;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[5];
  logic [DW-1:0] hist[4];
  logic [DW-1:0] pend_avg, pend_ac;
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            last_dv = -100;
  int            resp_cd = -1;
  int            mfill = 0;
  logic          withhold = 1'b0;
  logic          last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // engine answers 2 cycles after each eng_din_valid with the 4-sample mean
  task automatic engine();
    int   sum;
    logic fw;
    eng_avg_valid = 1'b0;
    if (eng_rstn !== 1'b1) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      resp_cd = -1;
    end else begin
      if (resp_cd > 0) resp_cd--;
      if (resp_cd == 0) begin
        resp_cd = -1;
        if (withhold) withhold = 1'b0;
        else begin
          eng_avg_valid = 1'b1;
          eng_avg = pend_avg;
          eng_ac = pend_ac;
          fw = WARM || mfill >= 3;
          if (fw) sb.push_back('{avg: pend_avg, ac: pend_ac, wf: mfill >= 3});
          if (mfill < 4) mfill++;
        end
      end
      if (eng_din_valid) begin
        hist[0] = hist[1];
        hist[1] = hist[2];
        hist[2] = hist[3];
        hist[3] = eng_din;
        sum = int'(hist[0]) + int'(hist[1]) + int'(hist[2]) + int'(hist[3]);
        pend_avg = DW'(sum / 4);
        pend_ac = eng_din - pend_avg;
        resp_cd = 2;
      end
    end
  endtask

  task automatic step();
    logic          acc;
    logic [DW-1:0] acc_d;
    exp_t          e;
    acc = s_valid && s_ready && !rst;
    acc_d = s_data;
    @(posedge clk);
    #1;
    cyc++;
    last_acc = acc;
    chk("din_valid", 32'(eng_din_valid), 32'(acc));
    if (eng_din_valid) begin
      chk("din_data", 32'(eng_din), 32'(acc_d));
      chk("din_spacing", 32'(cyc - last_dv >= GAP), 1);
      chk("din_overlap", 32'(resp_cd >= 0), 0);
      last_dv = cyc;
    end
    if (m_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got m_valid avg=%0d want none", m_avg);
      end else begin
        e = sb.pop_front();
        chk("sb_avg", 32'(m_avg), 32'(e.avg));
        chk("sb_ac", 32'(m_ac), 32'(e.ac));
        chk("sb_wf", 32'(win_full), 32'(e.wf));
      end
    end
    engine();
  endtask

  task automatic feed(input logic [DW-1:0] d);
    int n = 0;
    s_data = d;
    s_valid = 1'b1;
    do begin
      step();
      n++;
    end while (!last_acc && n < 30);
    if (!last_acc) begin
      total++;
      bad++;
      $display("FAIL feed_accept: got no accept want accept of %0d", d);
    end
    s_valid = 1'b0;
  endtask

  task automatic rst_window(input string tag);
    for (int i = 1; i <= RC; i++) begin
      step();
      chk(tag, 32'(eng_rstn), 32'(i == RC));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rstn"}, 32'(eng_rstn), 0);
    chk({tag, "_sready"}, 32'(s_ready), 0);
    chk({tag, "_din"}, 32'(eng_din), 0);
    chk({tag, "_dinv"}, 32'(eng_din_valid), 0);
    chk({tag, "_mavg"}, 32'(m_avg), 0);
    chk({tag, "_mac"}, 32'(m_ac), 0);
    chk({tag, "_mvalid"}, 32'(m_valid), 0);
    chk({tag, "_fill"}, 32'(fill_cnt), 0);
    chk({tag, "_err"}, 32'(err_timeout), 0);
    chk({tag, "_wf"}, 32'(win_full), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{d: 4,  avg: 1,  ac: 3, fwd: WARM, wf: 0, fill: 1};
    tbl[1] = '{d: 8,  avg: 3,  ac: 5, fwd: WARM, wf: 0, fill: 2};
    tbl[2] = '{d: 12, avg: 6,  ac: 6, fwd: WARM, wf: 0, fill: 3};
    tbl[3] = '{d: 16, avg: 10, ac: 6, fwd: 1,    wf: 1, fill: 4};
    tbl[4] = '{d: 20, avg: 14, ac: 6, fwd: 1,    wf: 1, fill: 4};
    rst = 1'b1;
    flush = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    eng_avg_valid = 1'b0;
    eng_avg = '0;
    eng_ac = '0;
    for (int i = 0; i < 4; i++) hist[i] = '0;

    repeat (2) step();
    chk_reset("reset");

    // release with s_valid held high: 4 low eng_rstn cycles, ready on the 5th
    rst = 1'b0;
    s_valid = 1'b1;
    s_data = tbl[0].d;
    for (int i = 0; i <= RC; i++) begin
      if (i > 0) step();
      chk("rel_rstn", 32'(eng_rstn), 32'(i == RC));
      chk("rel_sready", 32'(s_ready), 32'(i == RC));
    end

    for (int k = 0; k < 5; k++) begin
      feed(tbl[k].d);
      repeat (3) step();
      chk("tbl_mvalid", 32'(m_valid), 32'(tbl[k].fwd));
      if (tbl[k].fwd) begin
        chk("tbl_avg", 32'(m_avg), 32'(tbl[k].avg));
        chk("tbl_ac", 32'(m_ac), 32'(tbl[k].ac));
      end
      chk("tbl_wf", 32'(win_full), 32'(tbl[k].wf));
      chk("tbl_fill", 32'(fill_cnt), 32'(tbl[k].fill));
    end

    // lost response
    withhold = 1'b1;
    feed(24);
    repeat (TO - 1) step();
    chk("to_early", 32'(err_timeout), 0);
    step();
    mfill = 0;
    chk("to_err", 32'(err_timeout), 1);
    chk("to_rstn", 32'(eng_rstn), 0);
    chk("to_fill", 32'(fill_cnt), 0);
    chk("to_wf", 32'(win_full), 0);
    rst_window("to_window");
    feed(40);
    repeat (3) step();
    chk("resume_mvalid", 32'(m_valid), 32'(WARM));
    chk("resume_fill", 32'(fill_cnt), 1);
    chk("resume_wf", 32'(win_full), 0);
    repeat (3) begin
      feed(40);
      repeat (3) step();
    end
    chk("refill_wf", 32'(win_full), 1);
    chk("refill_avg", 32'(m_avg), 40);

    // flush colliding with a response and an offered sample
    feed(44);
    repeat (2) step();
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 99;
    if (eng_avg_valid) void'(sb.pop_back());
    mfill = 0;
    #1;
    chk("flush_sready", 32'(s_ready), 0);
    step();
    flush = 1'b0;
    s_valid = 1'b0;
    chk("flush_mvalid", 32'(m_valid), 0);
    chk("flush_wf", 32'(win_full), 0);
    chk("flush_rstn", 32'(eng_rstn), 0);
    chk("flush_err", 32'(err_timeout), 1);
    chk("flush_fill", 32'(fill_cnt), 0);
    rst_window("flush_window");

    // flush while idle in FILL, then again mid ENG_RST restarts the count
    flush = 1'b1;
    s_valid = 1'b1;
    s_data = 55;
    #1;
    chk("idle_flush_sready", 32'(s_ready), 0);
    step();
    flush = 1'b0;
    s_valid = 1'b0;
    chk("idle_flush_rstn", 32'(eng_rstn), 0);
    repeat (2) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    rst_window("reflush_window");

    // reset mid-RUN with a response outstanding
    for (int k = 1; k <= 4; k++) begin
      feed(DW'(k));
      repeat (3) step();
    end
    chk("run_wf", 32'(win_full), 1);
    feed(5);
    rst = 1'b1;
    step();
    chk_reset("midrst");
    rst = 1'b0;
    mfill = 0;
    rst_window("midrst_window");
    eng_avg_valid = 1'b1;
    eng_avg = 77;
    eng_ac = 77;
    step();
    chk("stray_mvalid", 32'(m_valid), 0);
    chk("stray_fill", 32'(fill_cnt), 0);

    repeat (3) step();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/moving_avg_ctrl.md
Name: moving_avg_ctrl

Overview:
Sequencer that sits in front of one moving-average engine, the getMovingAvg datapath with its din/din_valid inputs and moving_avg/ac_signal outputs. It accepts samples over a valid/ready handshake and paces them into the engine. It owns the engine reset and tracks window fill. It gates engine results so downstream only sees full-window averages, and it recovers from flush commands and lost responses.

Parameters:
FIFO_ADDR_WIDTH, 10, engine window is N = 2**FIFO_ADDR_WIDTH samples; must match the engine.
DIN_WIDTH, 16, sample, average and AC width in bits.
MIN_GAP, 2, minimum number of clk cycles between consecutive eng_din_valid pulses; must be >= 1.
RST_CYCLES, 4, number of cycles eng_rstn is held low per engine reset; must be >= 1.
RESP_TIMEOUT, 16, maximum number of cycles from eng_din_valid to eng_avg_valid before a fault is declared.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous reset, active-high.
flush  in  1  one-cycle pulse: restart the engine and the window.
s_data  in  DIN_WIDTH  signed input sample.
s_valid  in  1  s_data is valid.
s_ready  out  1  controller can accept a sample this cycle.
eng_rstn  out  1  engine reset, active-low.
eng_din  out  DIN_WIDTH  sample driven to the engine.
eng_din_valid  out  1  one-cycle strobe to the engine.
eng_avg  in  DIN_WIDTH  engine moving_avg.
eng_avg_valid  in  1  engine moving_avg_valid.
eng_ac  in  DIN_WIDTH  engine ac_signal; sampled on eng_avg_valid (the engine asserts both valids in the same cycle).
m_avg  out  DIN_WIDTH  forwarded average.
m_ac  out  DIN_WIDTH  forwarded AC component.
m_valid  out  1  m_avg and m_ac are valid; one-cycle pulse, no backpressure.
win_full  out  1  high in RUN state.
fill_cnt  out  FIFO_ADDR_WIDTH+1  number of responses received since the last engine reset; saturates at N.
err_timeout  out  1  sticky flag; cleared only by rst.

Behaviour:
- Reset values while rst=1:
  - state=ENG_RST, rst counter=0, eng_rstn=0.
  - eng_din=0, eng_din_valid=0, s_ready=0.
  - m_avg=0, m_ac=0, m_valid=0.
  - fill_cnt=0, err_timeout=0, gap counter=0, outstanding=0.
- FSM states:
  - ENG_RST: eng_rstn=0 for exactly RST_CYCLES cycles, then go to FILL. fill_cnt, outstanding and the gap counter are cleared on entry.
  - FILL: eng_rstn=1; samples are accepted; results are suppressed (m_valid=0).
  - RUN: eng_rstn=1; samples are accepted; every result is forwarded.
- s_ready (combinational) = (state is FILL or RUN) && !outstanding && gap counter==0 && !flush.
- Accept: on s_valid && s_ready, eng_din<=s_data and eng_din_valid<=1 for exactly one cycle, so latency is 1 cycle. On the same edge, outstanding<=1, the gap counter loads MIN_GAP-1 and the timeout counter loads 0.
- The gap counter decrements to 0 once per cycle. With MIN_GAP=1 the controller can accept back-to-back samples, each gated by outstanding.
- Response: on eng_avg_valid, outstanding<=0 and fill_cnt increments, saturating at N.
  - In FILL with fill_cnt==N-1: forward the result (m_avg<=eng_avg, m_ac<=eng_ac, m_valid<=1 next cycle) and go to RUN.
  - In FILL otherwise: drop the result.
  - In RUN: forward the result with 1-cycle latency.
- A stray eng_avg_valid with outstanding=0 is ignored: no count change, no forwarding.
- Timeout: while outstanding=1 the timeout counter increments. When it reaches RESP_TIMEOUT, set err_timeout, clear outstanding, and go to ENG_RST.
- flush=1 in any state (including ENG_RST): next state is ENG_RST with the rst counter restarted.
  - A sample offered in the same cycle is not accepted (s_ready=0).
  - An eng_avg_valid in the same cycle is dropped.
  - A pending eng_din_valid already registered still completes its one-cycle pulse.
- rst mid-operation: all state returns to reset values on the next edge, regardless of outstanding or pending outputs.
- Arithmetic: no arithmetic on data; the data path is registered pass-through only. Counters are unsigned and sized with $clog2 of their maximum value.

Optional Feature:
Macro MAVG_CTRL_WARMUP_PASS_EN.
- Defined: results are also forwarded in FILL, using the same 1-cycle latency as RUN. Downstream uses win_full to distinguish partial-window results.
- Undefined: FILL results are dropped as specified above.
- State transitions, fill_cnt and win_full are identical in both builds.

Test Plan:
Bench setup: FIFO_ADDR_WIDTH=2 (N=4), MIN_GAP=3, RST_CYCLES=4, RESP_TIMEOUT=8, and a behavioural engine that answers 2 cycles after each eng_din_valid with avg=sum of the last 4 samples / 4.
1. Release rst, drive s_valid=1 continuously -> eng_rstn low for 4 cycles; s_ready first high on cycle 5; eng_din_valid pulses spaced by at least 3 cycles and never overlapping an outstanding response.
2. Feed samples 4, 8, 12, 16, 20 -> first three responses dropped; after the 4th response m_valid with m_avg=10 and win_full=1; 5th sample gives m_avg=14; fill_cnt holds at 4.
3. Engine model withholds one response -> err_timeout=1 exactly 8 cycles after that eng_din_valid; eng_rstn low for 4 cycles; fill_cnt=0; operation resumes in FILL.
4. Pulse flush in the same cycle as s_valid and eng_avg_valid while in RUN -> sample not accepted, no m_valid, ENG_RST for 4 cycles, win_full=0, err_timeout unchanged.
5. Assert rst mid-RUN with a response outstanding -> all outputs return to reset values on the next edge; the late eng_avg_valid is ignored.
6. Build with MAVG_CTRL_WARMUP_PASS_EN and repeat scenario 2 -> m_valid for all responses: m_avg=1, 3, 6, 10, 14 with win_full=0, 0, 0, 1, 1.
